// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scan driver
// Optional build macro SEG_SCAN_BLANK_EN inserts BLANK_CYCLES of dark time
// at the start of every digit slot.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [7:0] seg_in_0,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  input  logic [7:0] seg_in_5,
  input  logic [7:0] seg_in_6,
  input  logic [7:0] seg_in_7,
  output logic [7:0] seg_an,
  output logic [7:0] seg_out,
  output logic [2:0] cur_digit,
  output logic       frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    cur_digit_q;
  logic [7:0]    seg_an_q;
  logic [7:0]    seg_out_q;
  logic          frame_tick_q;
  logic [7:0]    shadow_q [8];

  logic [7:0]    seg_in_w [8];
  logic [2:0]    next_digit_d;
  logic          slot_end_d;
  logic          wrap_d;
`ifndef SEG_SCAN_BLANK_EN
  logic [7:0]    next_an_d;
  logic [7:0]    next_pat_d;
`endif

  // Gather the eight input patterns and precompute the next-digit values.
  always_comb begin
    seg_in_w[0]  = seg_in_0;
    seg_in_w[1]  = seg_in_1;
    seg_in_w[2]  = seg_in_2;
    seg_in_w[3]  = seg_in_3;
    seg_in_w[4]  = seg_in_4;
    seg_in_w[5]  = seg_in_5;
    seg_in_w[6]  = seg_in_6;
    seg_in_w[7]  = seg_in_7;
    next_digit_d = cur_digit_q + 3'd1;
    slot_end_d   = (state_q == SCAN) && (presc_q == PRESC_LAST);
    wrap_d       = slot_end_d && (cur_digit_q == 3'd7);
`ifndef SEG_SCAN_BLANK_EN
    next_an_d    = ~(8'd1 << next_digit_d);
    // On the wrap edge digit 0 must show the value being captured right now.
    next_pat_d   = wrap_d ? seg_in_0 : shadow_q[next_digit_d];
`endif
  end

  // Scan FSM: prescaler, digit index, frame snapshot and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      cur_digit_q  <= 3'd0;
      seg_an_q     <= 8'hFF;
      seg_out_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= 8'hFF;
    end else begin
      frame_tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          presc_q     <= '0;
          cur_digit_q <= 3'd0;
          seg_an_q    <= 8'hFF;
          seg_out_q   <= 8'hFF;
          if (scan_en) begin
            for (int i = 0; i < 8; i++) shadow_q[i] <= seg_in_w[i];
`ifdef SEG_SCAN_BLANK_EN
            state_q   <= BLANK;
`else
            state_q   <= SCAN;
            seg_an_q  <= 8'hFE;
            seg_out_q <= seg_in_0;
`endif
          end
        end

        SCAN: begin
          if (!scan_en) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            cur_digit_q <= 3'd0;
            seg_an_q    <= 8'hFF;
            seg_out_q   <= 8'hFF;
          end else if (slot_end_d) begin
            presc_q     <= '0;
            cur_digit_q <= next_digit_d;
            if (wrap_d) begin
              frame_tick_q <= 1'b1;
              for (int i = 0; i < 8; i++) shadow_q[i] <= seg_in_w[i];
            end
`ifdef SEG_SCAN_BLANK_EN
            state_q   <= BLANK;
            seg_an_q  <= 8'hFF;
            seg_out_q <= 8'hFF;
`else
            seg_an_q  <= next_an_d;
            seg_out_q <= next_pat_d;
`endif
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end

`ifdef SEG_SCAN_BLANK_EN
        BLANK: begin
          if (!scan_en) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            cur_digit_q <= 3'd0;
            seg_an_q    <= 8'hFF;
            seg_out_q   <= 8'hFF;
          end else begin
            // Prescaler keeps counting so the whole slot stays SCAN_DIV long.
            presc_q <= presc_q + 1'b1;
            if (presc_q == BLANK_LAST) begin
              state_q   <= SCAN;
              seg_an_q  <= ~(8'd1 << cur_digit_q);
              seg_out_q <= shadow_q[cur_digit_q];
            end
          end
        end
`endif

        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg_an     = seg_an_q;
  assign seg_out    = seg_out_q;
  assign cur_digit  = cur_digit_q;
  assign frame_tick = frame_tick_q;

endmodule
